// File: rtl/fir_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fir_pkg : shared widths, saturation limits, rounding modes and helpers     |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
package fir_pkg;

  localparam int c_IN_WIDTH_DEF  = 25;
  localparam int c_OUT_WIDTH_DEF = 16;
  localparam int c_SAT_MAX_DEF   = (1 << (c_OUT_WIDTH_DEF - 1)) - 1;
  localparam int c_SAT_MIN_DEF   = -(1 << (c_OUT_WIDTH_DEF - 1));

  typedef enum logic {
    RND_TRUNC  = 1'b0,
    RND_HALFUP = 1'b1
  } rnd_mode_e;

  function automatic int f_clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Lanes entering tree level s: each level halves the count, rounding up.
  function automatic int f_lanes_at(input int n, input int s);
    int l;
    l = n;
    for (int i = 0; i < s; i++) begin
      l = (l + 1) / 2;
    end
    return l;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fir_sum_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fir_sum_stage : one registered pairwise-add level of the FIR sum tree       |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module fir_sum_stage #(
  parameter int LANES = 2,
  parameter int W     = 25
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [LANES*W-1:0]                 i_data,
  input  logic                               i_valid,
  input  logic                               i_mode,
  output logic [((LANES+1)/2)*(W+1)-1:0]     o_data,
  output logic                               o_valid,
  output logic                               o_mode
);

  localparam int c_OL = (LANES + 1) / 2;

  logic [c_OL*(W+1)-1:0] w_sum;
  logic [c_OL*(W+1)-1:0] r_data;
  logic                  r_valid;
  logic                  r_mode;

  for (genvar k = 0; k < c_OL; k++) begin : g_pair
    if (2*k + 1 < LANES) begin : g_add
      assign w_sum[k*(W+1) +: W+1] =
          {i_data[(2*k+1)*W-1], i_data[2*k*W +: W]} +
          {i_data[(2*k+2)*W-1], i_data[(2*k+1)*W +: W]};
    end else begin : g_pass
      // Odd leftover lane: sign-extend and carry through unchanged.
      assign w_sum[k*(W+1) +: W+1] = {i_data[(2*k+1)*W-1], i_data[2*k*W +: W]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_mode  <= 1'b0;
    end else begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_data <= w_sum;
        r_mode <= i_mode;
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_mode  = r_mode;

endmodule
`default_nettype wire

// File: rtl/fir_sum_tree.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | fir_sum_tree : pipelined MAC summer with rounded shift and saturation       |
// | Optional saturation counter built when FIR_SUM_SATCNT_EN is defined         |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module fir_sum_tree
  import fir_pkg::*;
#(
  parameter int NUM_MAC   = 8,
  parameter int IN_WIDTH  = c_IN_WIDTH_DEF,
  parameter int OUT_WIDTH = c_OUT_WIDTH_DEF,
  parameter int SHIFT     = 0
) (
  input  logic                        iClk12M,
  input  logic                        iRsn,
  input  logic [NUM_MAC*IN_WIDTH-1:0] iMacBus,
  input  logic                        iEnSum,
  input  logic                        iRndMode,
  input  logic                        iSatClr,
  output logic [OUT_WIDTH-1:0]        oFirOut,
  output logic                        oValid,
  output logic                        oSatFlag,
  output logic [15:0]                 oSatCnt
);

  localparam int TREE_ST  = f_clog2(NUM_MAC);
  localparam int SUM_W    = IN_WIDTH + TREE_ST;
  localparam int c_BUSW   = NUM_MAC * SUM_W;
  // Working width holds the full sum plus rounding carry and both clip limits.
  localparam int c_EXT_W  = ((SUM_W + 1 > OUT_WIDTH) ? SUM_W + 1 : OUT_WIDTH) + 1;
  localparam int c_RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

  localparam logic [c_EXT_W-1:0] c_RND_INC =
      (SHIFT > 0) ? (c_EXT_W'(1) << c_RND_SH) : '0;
  localparam logic signed [c_EXT_W-1:0] c_SAT_MAX =
      {{(c_EXT_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [c_EXT_W-1:0] c_SAT_MIN =
      {{(c_EXT_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic [c_BUSW-1:0] w_bus  [0:TREE_ST];
  logic              w_vld  [0:TREE_ST];
  logic              w_mode [0:TREE_ST];

  assign w_bus[0]  = c_BUSW'(iMacBus);
  assign w_vld[0]  = iEnSum;
  assign w_mode[0] = iRndMode;

  for (genvar s = 0; s < TREE_ST; s++) begin : g_stage
    localparam int c_LANES = f_lanes_at(NUM_MAC, s);
    localparam int c_W     = IN_WIDTH + s;

    logic [((c_LANES+1)/2)*(c_W+1)-1:0] w_out;

    fir_sum_stage #(
      .LANES (c_LANES),
      .W     (c_W)
    ) u_stage (
      .clk     (iClk12M),
      .rst_n   (iRsn),
      .i_data  (w_bus[s][c_LANES*c_W-1:0]),
      .i_valid (w_vld[s]),
      .i_mode  (w_mode[s]),
      .o_data  (w_out),
      .o_valid (w_vld[s+1]),
      .o_mode  (w_mode[s+1])
    );

    assign w_bus[s+1] = c_BUSW'(w_out);
  end

  logic signed [SUM_W-1:0]   w_sum;
  logic signed [c_EXT_W-1:0] w_ext;
  logic signed [c_EXT_W-1:0] w_rnd;
  logic signed [c_EXT_W-1:0] w_shf;
  logic                      w_hi;
  logic                      w_lo;
  logic [OUT_WIDTH-1:0]      w_clip;
  logic                      w_unused_bus;

  assign w_sum        = w_bus[TREE_ST][SUM_W-1:0];
  assign w_unused_bus = ^w_bus[TREE_ST];
  assign w_ext        = {{(c_EXT_W-SUM_W){w_sum[SUM_W-1]}}, w_sum};

  always_comb begin
    w_rnd = w_ext;
    if ((SHIFT > 0) && (w_mode[TREE_ST] == RND_HALFUP)) begin
      w_rnd = w_ext + c_RND_INC;
    end
  end

  assign w_shf  = w_rnd >>> SHIFT;
  assign w_hi   = (w_shf > c_SAT_MAX);
  assign w_lo   = (w_shf < c_SAT_MIN);
  assign w_clip = w_hi ? c_SAT_MAX[OUT_WIDTH-1:0] :
                  w_lo ? c_SAT_MIN[OUT_WIDTH-1:0] : w_shf[OUT_WIDTH-1:0];

  logic [OUT_WIDTH-1:0] r_out;
  logic                 r_valid;
  logic                 r_sat;

  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      r_out   <= '0;
      r_valid <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_valid <= w_vld[TREE_ST];
      r_sat   <= w_vld[TREE_ST] & (w_hi | w_lo);
      if (w_vld[TREE_ST]) begin
        r_out <= w_clip;
      end
    end
  end

  assign oFirOut  = r_out;
  assign oValid   = r_valid;
  assign oSatFlag = r_sat;

`ifdef FIR_SUM_SATCNT_EN
  logic [15:0] r_sat_cnt;

  // Clear has priority over a coincident increment; count sticks at all-ones.
  always_ff @(posedge iClk12M or negedge iRsn) begin
    if (!iRsn) begin
      r_sat_cnt <= '0;
    end else if (iSatClr) begin
      r_sat_cnt <= '0;
    end else if (r_valid && r_sat && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign oSatCnt = r_sat_cnt;
`else
  logic w_unused_satclr;

  assign w_unused_satclr = iSatClr;
  assign oSatCnt         = '0;
`endif

endmodule
`default_nettype wire
